// File: rtl/frame_serializer_pkg.sv
// Shared types and width helpers for the frame serializer.
// Ports: none (package only).
// Used by frame_serializer and frame_serializer_buf.
package frame_serializer_pkg;

  // Occupancy of one frame bank.
  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  localparam int DEF_BIT_WIDTH = 32;
  localparam int DEF_N_SAMPLES = 8;

  // Width of the beat index that walks a frame of up to n words.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a frame length field: one extra bit so the value n itself fits.
  function automatic int len_w(input int n);
    return idx_w(n) + 1;
  endfunction

endpackage

// File: rtl/frame_serializer_buf.sv
// One frame bank: N_SAMPLES word registers plus a length and an EMPTY/FULL state.
// Ports: clk/reset (sync, active-high); i_wr_en/i_wr_msg/i_wr_len load a frame and
// mark it FULL; i_clr returns it to EMPTY; i_rd_idx selects o_rd_word; o_len/o_full expose status.
module frame_serializer_buf
  import frame_serializer_pkg::*;
#(
  parameter  int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter  int N_SAMPLES = DEF_N_SAMPLES,
  localparam int IDX_W     = idx_w(N_SAMPLES),
  localparam int LEN_W     = len_w(N_SAMPLES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_wr_en,
  input  logic [BIT_WIDTH-1:0] i_wr_msg [N_SAMPLES],
  input  logic [LEN_W-1:0]     i_wr_len,
  input  logic                 i_clr,
  input  logic [IDX_W-1:0]     i_rd_idx,
  output logic [BIT_WIDTH-1:0] o_rd_word,
  output logic [LEN_W-1:0]     o_len,
  output logic                 o_full
);

  logic [BIT_WIDTH-1:0] r_word [N_SAMPLES];
  logic [LEN_W-1:0]     r_len;
  buf_state_e           r_state;

  // A load only happens into an EMPTY bank and a clear only from a FULL one,
  // so the two never collide; load still takes priority for safety.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SAMPLES; i++) r_word[i] <= '0;
      r_len   <= '0;
      r_state <= BUF_EMPTY;
    end else if (i_wr_en) begin
      for (int i = 0; i < N_SAMPLES; i++) r_word[i] <= i_wr_msg[i];
      r_len   <= i_wr_len;
      r_state <= BUF_FULL;
    end else if (i_clr) begin
      r_state <= BUF_EMPTY;
    end
  end

  assign o_rd_word = r_word[i_rd_idx];
  assign o_len     = r_len;
  assign o_full    = (r_state == BUF_FULL);

endmodule

// File: rtl/frame_serializer.sv
// Double-buffered parallel-to-serial converter: captures a frame of up to N_SAMPLES
// words in one handshake and emits it one word per cycle, flagging the last word.
// Ports: clk/reset (sync, active-high); recv_msg/recv_len/recv_val/recv_rdy frame input;
// send_msg/send_val/send_rdy/send_last serial output. recv_rdy depends on registered state only.
// Build option FRAME_SERIALIZER_REVERSE_EN: emit each frame from word len-1 down to word 0.
module frame_serializer
  import frame_serializer_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int N_SAMPLES = DEF_N_SAMPLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BIT_WIDTH-1:0]          recv_msg [N_SAMPLES],
  input  logic [len_w(N_SAMPLES)-1:0]   recv_len,
  input  logic                          recv_val,
  output logic                          recv_rdy,
  output logic [BIT_WIDTH-1:0]          send_msg,
  output logic                          send_val,
  input  logic                          send_rdy,
  output logic                          send_last
);

  localparam int IDX_W = idx_w(N_SAMPLES);
  localparam int LEN_W = len_w(N_SAMPLES);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(N_SAMPLES);

  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [IDX_W-1:0] r_idx;

  logic [1:0]           w_full;
  logic [LEN_W-1:0]     w_len  [2];
  logic [BIT_WIDTH-1:0] w_word [2];
  logic [1:0]           w_wr_en;
  logic [1:0]           w_clr;
  logic [LEN_W-1:0]     w_len_clamp;
  logic                 w_cap;
  logic                 w_fire;
  logic                 w_at_end;
  logic                 w_last_fire;

  // Zero or oversize lengths mean "whole frame".
  assign w_len_clamp = (recv_len == '0 || recv_len > MAX_LEN) ? MAX_LEN : recv_len;

  assign recv_rdy    = ~w_full[r_wr_ptr];
  assign send_val    = w_full[r_rd_ptr];
  assign send_msg    = w_word[r_rd_ptr];
  assign w_cap       = recv_val && recv_rdy;
  assign w_fire      = send_val && send_rdy;
  assign w_last_fire = w_fire && w_at_end;
  assign send_last   = send_val && w_at_end;

`ifdef FRAME_SERIALIZER_REVERSE_EN
  assign w_at_end = (r_idx == '0);
`else
  logic [LEN_W-1:0] w_rd_len;
  assign w_rd_len = w_len[r_rd_ptr];
  assign w_at_end = ({1'b0, r_idx} == w_rd_len - LEN_W'(1));
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign w_wr_en[b] = w_cap && (r_wr_ptr == 1'(b));
    assign w_clr[b]   = w_last_fire && (r_rd_ptr == 1'(b));

    frame_serializer_buf #(
      .BIT_WIDTH (BIT_WIDTH),
      .N_SAMPLES (N_SAMPLES)
    ) u_buf (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (w_wr_en[b]),
      .i_wr_msg  (recv_msg),
      .i_wr_len  (w_len_clamp),
      .i_clr     (w_clr[b]),
      .i_rd_idx  (r_idx),
      .o_rd_word (w_word[b]),
      .o_len     (w_len[b]),
      .o_full    (w_full[b])
    );
  end

`ifdef FRAME_SERIALIZER_REVERSE_EN
  // Length of whichever bank drains next after a last fire; if that bank is
  // being loaded on the same edge, its length comes straight from the input.
  logic [LEN_W-1:0] w_nxt_len;
  assign w_nxt_len = (w_cap && (r_wr_ptr == ~r_rd_ptr)) ? w_len_clamp : w_len[~r_rd_ptr];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_idx    <= '0;
    end else begin
      if (w_cap)       r_wr_ptr <= ~r_wr_ptr;
      if (w_last_fire) r_rd_ptr <= ~r_rd_ptr;
`ifdef FRAME_SERIALIZER_REVERSE_EN
      // The index is preloaded whenever a bank becomes the drain bank: on a
      // last fire (stale if the next bank is empty, reloaded when it fills),
      // or on a capture while both banks are empty (wr_ptr == rd_ptr).
      if (w_last_fire)
        r_idx <= IDX_W'(w_nxt_len - LEN_W'(1));
      else if (w_cap && (r_wr_ptr == r_rd_ptr))
        r_idx <= IDX_W'(w_len_clamp - LEN_W'(1));
      else if (w_fire)
        r_idx <= r_idx - IDX_W'(1);
`else
      if (w_last_fire)
        r_idx <= '0;
      else if (w_fire)
        r_idx <= r_idx + IDX_W'(1);
`endif
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer (BIT_WIDTH=32, N_SAMPLES=8).
// Expected word order follows FRAME_SERIALIZER_REVERSE_EN when it is defined.
// Ends with one TB_RESULT summary line.
module tb_frame_serializer;

  localparam int BW = 32;
  localparam int NS = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] recv_msg [NS];
  logic [LW-1:0] recv_len;
  logic          recv_val;
  logic          recv_rdy;
  logic [BW-1:0] send_msg;
  logic          send_val;
  logic          send_rdy;
  logic          send_last;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] pat      = 32'hA5C3_3C5A;

  always #5 clk = ~clk;

  frame_serializer #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) dut (
    .clk       (clk),
    .reset     (reset),
    .recv_msg  (recv_msg),
    .recv_len  (recv_len),
    .recv_val  (recv_val),
    .recv_rdy  (recv_rdy),
    .send_msg  (send_msg),
    .send_val  (send_val),
    .send_rdy  (send_rdy),
    .send_last (send_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Word expected on beat b of a frame whose words are base+i, with L valid words.
  function automatic logic [31:0] exp_word(input logic [31:0] base, input int L, input int b);
`ifdef FRAME_SERIALIZER_REVERSE_EN
    return base + 32'(L - 1 - b);
`else
    return base + 32'(b);
`endif
  endfunction

  // Present a frame; words past the valid count carry a junk marker.
  task automatic load_frame(input logic [31:0] base, input int len_field, input int valid);
    for (int i = 0; i < NS; i++)
      recv_msg[i] = (i < valid) ? base + 32'(i) : (32'hEE00_0000 | 32'(i));
    recv_len = LW'(len_field);
    recv_val = 1'b1;
  endtask

  task automatic beat(input string tag, input logic [31:0] base, input int L, input int b);
    chk($sformatf("%s_val%0d", tag, b), 32'(send_val), 32'd1);
    chk($sformatf("%s_msg%0d", tag, b), send_msg, exp_word(base, L, b));
    chk($sformatf("%s_last%0d", tag, b), 32'(send_last), 32'(b == L - 1));
  endtask

  // Capture one frame with send_rdy high and check every beat plus the idle after.
  task automatic run_frame(input string tag, input logic [31:0] base, input int len_field, input int L);
    load_frame(base, len_field, L);
    chk({tag, "_rdy"}, 32'(recv_rdy), 32'd1);
    step;
    recv_val = 1'b0;
    chk({tag, "_rdy_after"}, 32'(recv_rdy), 32'd1);
    for (int b = 0; b < L; b++) begin
      beat(tag, base, L, b);
      step;
    end
    chk({tag, "_idle"}, 32'(send_val), 32'd0);
  endtask

  initial begin
    int fires;
    reset    = 1'b1;
    recv_val = 1'b0;
    send_rdy = 1'b0;
    recv_len = '0;
    for (int i = 0; i < NS; i++) recv_msg[i] = '0;
    step;
    step;
    reset = 1'b0;

    // Reset state
    chk("rst_recv_rdy",  32'(recv_rdy),  32'd1);
    chk("rst_send_val",  32'(send_val),  32'd0);
    chk("rst_send_last", 32'(send_last), 32'd0);
    chk("rst_send_msg",  send_msg,       32'd0);

    // Single full frame
    send_rdy = 1'b1;
    run_frame("f8", 32'hA0, 8, 8);

    // Back-to-back frames with recv_val held, third frame stalls
    load_frame(32'h1, 3, 3);
    step;                                   // frame 1 captured
    load_frame(32'h20, 8, 8);
    beat("bb1", 32'h1, 3, 0);
    chk("bb_rdy0", 32'(recv_rdy), 32'd1);
    step;                                   // frame 2 captured, beat 0 fired
    load_frame(32'h40, 2, 2);
    beat("bb1", 32'h1, 3, 1);
    chk("bb_rdy1", 32'(recv_rdy), 32'd0);
    step;
    beat("bb1", 32'h1, 3, 2);
    chk("bb_rdy2", 32'(recv_rdy), 32'd0);
    step;                                   // frame 1 last fire
    chk("bb_rdy3", 32'(recv_rdy), 32'd1);
    beat("bb2", 32'h20, 8, 0);
    step;                                   // frame 3 captured
    recv_val = 1'b0;
    for (int b = 1; b < 8; b++) begin
      beat("bb2", 32'h20, 8, b);
      step;
    end
    for (int b = 0; b < 2; b++) begin
      beat("bb3", 32'h40, 2, b);
      step;
    end
    chk("bb_idle", 32'(send_val), 32'd0);

    // Stalls from a fixed send_rdy pattern on a len=5 frame
    send_rdy = 1'b0;
    load_frame(32'h50, 5, 5);
    step;
    recv_val = 1'b0;
    fires = 0;
    for (int c = 0; c < 32; c++) begin
      if (send_val) begin
        chk($sformatf("bp_msg_c%0d", c), send_msg, exp_word(32'h50, 5, fires));
        chk($sformatf("bp_last_c%0d", c), 32'(send_last), 32'(fires == 4));
      end
      send_rdy = pat[c];
      if (send_val && send_rdy) fires++;
      step;
    end
    chk("bp_fires", 32'(fires), 32'd5);
    chk("bp_idle", 32'(send_val), 32'd0);
    send_rdy = 1'b1;

    // Length clamp and single-word frame
    run_frame("len0", 32'hB0, 0, 8);
    run_frame("len9", 32'hC0, 9, 8);
    run_frame("len1", 32'hD0, 1, 1);
    run_frame("f5",   32'h10, 5, 5);

    // Reset on the 4th beat with a second frame queued
    load_frame(32'h60, 8, 8);
    step;
    load_frame(32'h70, 3, 3);
    beat("rm", 32'h60, 8, 0);
    step;
    recv_val = 1'b0;
    beat("rm", 32'h60, 8, 1);
    step;
    beat("rm", 32'h60, 8, 2);
    step;
    beat("rm", 32'h60, 8, 3);
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("rm_send_val",  32'(send_val),  32'd0);
    chk("rm_recv_rdy",  32'(recv_rdy),  32'd1);
    chk("rm_send_last", 32'(send_last), 32'd0);
    chk("rm_send_msg",  send_msg,       32'd0);
    for (int c = 0; c < 5; c++) begin
      step;
      chk($sformatf("rm_quiet%0d", c), 32'(send_val), 32'd0);
    end
    run_frame("post", 32'hE0, 2, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
